// File: rtl/pci_burst_initiator_if.sv
// pci_burst_initiator_if: bus bundle, where master drives REQ/FRAME/IRDY/I_AM_OWNER/phase_cnt/done/abort and slave drives the requests and bus inputs
interface pci_burst_initiator_if #(parameter int LEN_W = 4);
  logic             start;
  logic [LEN_W-1:0] burst_len;
  logic             GNT;
  logic             GLOBAL_FRAME;
  logic             GLOBAL_IRDY;
  logic             TRDY;
  logic             DEVSEL;
  logic             REQ;
  logic             FRAME;
  logic             IRDY;
  logic             I_AM_OWNER;
  logic [LEN_W-1:0] phase_cnt;
  logic             done;
  logic             abort;
  modport master (
    input  start, burst_len, GNT, GLOBAL_FRAME, GLOBAL_IRDY, TRDY, DEVSEL,
    output REQ, FRAME, IRDY, I_AM_OWNER, phase_cnt, done, abort
  );
  modport slave (
    output start, burst_len, GNT, GLOBAL_FRAME, GLOBAL_IRDY, TRDY, DEVSEL,
    input  REQ, FRAME, IRDY, I_AM_OWNER, phase_cnt, done, abort
  );
endinterface

// File: rtl/pci_burst_initiator.sv
// pci_burst_initiator: PCI burst master FSM with clk/rst plus bus.master carrying request, grant, target handshake, bus drives and done/abort pulses
module pci_burst_initiator #(
  parameter int MAX_LEN   = 8,
  parameter int LEN_W     = 4,
  parameter int DEVSEL_TO = 5
) (
  input logic                   clk,
  input logic                   rst,
  pci_burst_initiator_if.master bus
);
  localparam int DW = $clog2(DEVSEL_TO + 1);
  typedef enum logic [2:0] {IDLE, REQUEST, ADDR, DATA, ABORT, TURN} state_t;
  state_t           state_q, state_d;
  logic             req_q, req_d, frame_q, frame_d, irdy_q, irdy_d, own_q, own_d;
  logic             done_q, done_d, abort_q, abort_d, dseen_q, dseen_d;
  logic [LEN_W-1:0] cnt_q, cnt_d, len_q, len_d, eff_len, cnt_inc;
  logic [DW-1:0]    dcnt_q, dcnt_d, dcnt_inc;
  logic             xfer;
  assign eff_len  = bus.burst_len == '0 ? LEN_W'(1) :
                    bus.burst_len > LEN_W'(MAX_LEN) ? LEN_W'(MAX_LEN) : bus.burst_len;
  assign cnt_inc  = cnt_q + LEN_W'(1);
  assign dcnt_inc = dcnt_q + DW'(1);
  assign xfer     = !irdy_q && !bus.TRDY && !bus.DEVSEL;
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    frame_d = frame_q;
    irdy_d  = irdy_q;
    own_d   = own_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    dcnt_d  = dcnt_q;
    dseen_d = dseen_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = REQUEST;
        req_d   = 1'b0;
        len_d   = eff_len;
        cnt_d   = '0;
      end
      REQUEST: if (!bus.GNT && bus.GLOBAL_FRAME && bus.GLOBAL_IRDY) begin
        state_d = ADDR;
        frame_d = 1'b0;
        req_d   = 1'b1;
        own_d   = 1'b1;
      end
      ADDR: begin
        state_d = DATA;
        irdy_d  = 1'b0;
        frame_d = len_q == LEN_W'(1);
        dcnt_d  = '0;
        dseen_d = 1'b0;
      end
      DATA: if (!dseen_q && bus.DEVSEL && dcnt_inc == DW'(DEVSEL_TO)) begin
        state_d = ABORT;
        frame_d = 1'b1;
        dcnt_d  = dcnt_inc;
      end else begin
        dseen_d = dseen_q || !bus.DEVSEL;
        dcnt_d  = (!dseen_q && bus.DEVSEL) ? dcnt_inc : dcnt_q;
        if (xfer) begin
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = TURN;
            frame_d = 1'b1;
            irdy_d  = 1'b1;
            own_d   = 1'b0;
            done_d  = 1'b1;
          end else if (cnt_inc + LEN_W'(1) == len_q) begin
            frame_d = 1'b1;
          end
        end
      end
      ABORT: begin
        state_d = TURN;
        irdy_d  = 1'b1;
        own_d   = 1'b0;
        abort_d = 1'b1;
      end
      TURN: begin
        state_d = IDLE;
        req_d   = 1'b1;
        frame_d = 1'b1;
        irdy_d  = 1'b1;
        own_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b1;
      frame_q <= 1'b1;
      irdy_q  <= 1'b1;
      own_q   <= 1'b0;
      cnt_q   <= '0;
      len_q   <= LEN_W'(1);
      dcnt_q  <= '0;
      dseen_q <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      frame_q <= frame_d;
      irdy_q  <= irdy_d;
      own_q   <= own_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      dcnt_q  <= dcnt_d;
      dseen_q <= dseen_d;
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end
  assign bus.REQ        = req_q;
  assign bus.FRAME      = frame_q;
  assign bus.IRDY       = irdy_q;
  assign bus.I_AM_OWNER = own_q;
  assign bus.phase_cnt  = cnt_q;
  assign bus.done       = done_q;
  assign bus.abort      = abort_q;
endmodule

// File: tb/tb_pci_burst_initiator.sv
// tb_pci_burst_initiator: randomized transaction-level check of pci_burst_initiator against a per-burst cycle-count model
module tb_pci_burst_initiator;
  localparam int MAX_LEN   = 8;
  localparam int DEVSEL_TO = 5;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  always #5 clk = ~clk;
  pci_burst_initiator_if #(.LEN_W(4)) bus_if ();
  pci_burst_initiator #(.MAX_LEN(MAX_LEN), .LEN_W(4), .DEVSEL_TO(DEVSEL_TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );
  task automatic idle_inputs();
    bus_if.start        = 1'b0;
    bus_if.burst_len    = 4'd1;
    bus_if.GNT          = 1'b1;
    bus_if.GLOBAL_FRAME = 1'b1;
    bus_if.GLOBAL_IRDY  = 1'b1;
    bus_if.TRDY         = 1'b1;
    bus_if.DEVSEL       = 1'b1;
  endtask
  task automatic test_reset();
    logic [9:0] obs;
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    obs = {bus_if.REQ, bus_if.FRAME, bus_if.IRDY, bus_if.I_AM_OWNER, bus_if.done, bus_if.abort, bus_if.phase_cnt};
    checks++;
    if (obs !== 10'b1110_00_0000) begin
      failures++;
      $display("FAIL reset_state: got %b expected %b", obs, 10'b1110_00_0000);
    end
    bus_if.start = 1'b1;
    bus_if.GNT   = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_if.REQ !== 1'b1) begin
      failures++;
      $display("FAIL reset_dominates_start: REQ got %b expected 1", bus_if.REQ);
    end
    bus_if.start = 1'b0;
    bus_if.GNT   = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus_if.REQ, bus_if.I_AM_OWNER} !== 2'b10) begin
      failures++;
      $display("FAIL reset_release_idle: got %b expected 10", {bus_if.REQ, bus_if.I_AM_OWNER});
    end
  endtask
  // wmode: 0 no waits, 1 random waits, 2 two waits on the second phase
  task automatic run_txn(input string name, input logic [3:0] bl, input int g, input int gi, input int d, input int wmode);
    int w[8];
    int eff, sw = 0, sw1 = 0, rk = 0, dk = 0, ph = 0, wk = 0;
    int req_low = 0, frame_low = 0, irdy_low = 0, fin = 0, viol = 0, dn = 0, ab = 0;
    int e_irdy, e_frame, e_fin, e_pc, e_req;
    bit ended = 0, is_ab;
    eff = bl == 0 ? 1 : (int'(bl) > MAX_LEN ? MAX_LEN : int'(bl));
    for (int i = 0; i < 8; i++) w[i] = wmode == 1 ? int'($urandom_range(0, 2)) : ((wmode == 2 && i == 1) ? 2 : 0);
    for (int i = 0; i < eff; i++) begin
      sw += w[i];
      if (i < eff - 1) sw1 += w[i];
    end
    is_ab = d >= DEVSEL_TO;
    e_req = (g > gi ? g : gi) + 1;
    if (is_ab) begin
      e_irdy  = DEVSEL_TO + 1;
      e_frame = eff > 1 ? DEVSEL_TO + 1 : 1;
      e_fin   = eff > 1 ? 1 : DEVSEL_TO + 1;
      e_pc    = 0;
    end else begin
      e_irdy  = d + sw + eff;
      e_frame = eff > 1 ? d + sw1 + eff : 1;
      e_fin   = (eff == 1 ? d : 0) + w[eff-1] + 1;
      e_pc    = eff;
    end
    @(negedge clk);
    bus_if.start     = 1'b1;
    bus_if.burst_len = bl;
    for (int cyc = 0; cyc < 300 && !ended; cyc++) begin
      @(negedge clk);
      if (!bus_if.REQ) req_low++;
      if (!bus_if.FRAME) frame_low++;
      if (!bus_if.IRDY) irdy_low++;
      if (bus_if.I_AM_OWNER && bus_if.FRAME && !bus_if.IRDY) fin++;
      if (bus_if.I_AM_OWNER && bus_if.FRAME && bus_if.IRDY) viol++;
      dn += int'(bus_if.done);
      ab += int'(bus_if.abort);
      if (bus_if.done || bus_if.abort) ended = 1;
      else begin
        bus_if.start     = (!bus_if.REQ || bus_if.I_AM_OWNER) ? 1'($urandom_range(0, 1)) : 1'b0;
        bus_if.burst_len = 4'($urandom_range(0, 15));
        if (!bus_if.REQ) begin
          bus_if.GNT         = rk >= g ? 1'b0 : 1'b1;
          bus_if.GLOBAL_IRDY = rk < gi ? 1'b0 : 1'b1;
          rk++;
        end else begin
          bus_if.GNT         = 1'($urandom_range(0, 1));
          bus_if.GLOBAL_IRDY = 1'b1;
        end
        if (!bus_if.IRDY) begin
          if (dk < d) begin
            bus_if.DEVSEL = 1'b1;
            bus_if.TRDY   = 1'b1;
          end else begin
            bus_if.DEVSEL = 1'b0;
            if (wk < w[ph]) begin
              bus_if.TRDY = 1'b1;
              wk++;
            end else begin
              bus_if.TRDY = 1'b0;
              ph = ph < 7 ? ph + 1 : ph;
              wk = 0;
            end
          end
          dk++;
        end else begin
          bus_if.DEVSEL = 1'b1;
          bus_if.TRDY   = 1'b1;
        end
      end
    end
    if (!ended) begin
      checks++;
      failures++;
      $display("FAIL %s timeout: no done/abort within 300 cycles", name);
    end
    checks++;
    if (dn !== (is_ab ? 0 : 1)) begin
      failures++;
      $display("FAIL %s done_pulses: got %0d expected %0d", name, dn, is_ab ? 0 : 1);
    end
    checks++;
    if (ab !== (is_ab ? 1 : 0)) begin
      failures++;
      $display("FAIL %s abort_pulses: got %0d expected %0d", name, ab, is_ab ? 1 : 0);
    end
    checks++;
    if (int'(bus_if.phase_cnt) !== e_pc) begin
      failures++;
      $display("FAIL %s phase_cnt: got %0d expected %0d", name, bus_if.phase_cnt, e_pc);
    end
    checks++;
    if (req_low !== e_req) begin
      failures++;
      $display("FAIL %s req_low_cycles: got %0d expected %0d", name, req_low, e_req);
    end
    checks++;
    if (frame_low !== e_frame) begin
      failures++;
      $display("FAIL %s frame_low_cycles: got %0d expected %0d", name, frame_low, e_frame);
    end
    checks++;
    if (irdy_low !== e_irdy) begin
      failures++;
      $display("FAIL %s irdy_low_cycles: got %0d expected %0d", name, irdy_low, e_irdy);
    end
    checks++;
    if (fin !== e_fin) begin
      failures++;
      $display("FAIL %s final_phase_cycles: got %0d expected %0d", name, fin, e_fin);
    end
    checks++;
    if (viol !== 0) begin
      failures++;
      $display("FAIL %s owner_released_bus: got %0d expected 0", name, viol);
    end
    checks++;
    if ({bus_if.REQ, bus_if.FRAME, bus_if.IRDY, bus_if.I_AM_OWNER} !== 4'b1110) begin
      failures++;
      $display("FAIL %s turn_released: got %b expected 1110", name, {bus_if.REQ, bus_if.FRAME, bus_if.IRDY, bus_if.I_AM_OWNER});
    end
    bus_if.start     = 1'b1;
    bus_if.burst_len = 4'd1;
    bus_if.GNT       = 1'b0;
    bus_if.TRDY      = 1'b1;
    bus_if.DEVSEL    = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus_if.REQ, bus_if.FRAME, bus_if.IRDY, bus_if.I_AM_OWNER, bus_if.done, bus_if.abort} !== 6'b111000) begin
      failures++;
      $display("FAIL %s idle_after_turn: got %b expected 111000", name,
               {bus_if.REQ, bus_if.FRAME, bus_if.IRDY, bus_if.I_AM_OWNER, bus_if.done, bus_if.abort});
    end
    bus_if.start = 1'b0;
    bus_if.GNT   = 1'b1;
  endtask
  task automatic test_single();
    run_txn("single", 4'd1, 1, 0, 0, 0);
  endtask
  task automatic test_wait_states();
    run_txn("wait_states", 4'd4, 0, 0, 0, 2);
  endtask
  task automatic test_clamp();
    run_txn("len_zero", 4'd0, 0, 0, 0, 0);
    run_txn("len_clamp", 4'd15, 2, 0, 1, 1);
  endtask
  task automatic test_abort();
    run_txn("abort_len1", 4'd1, 0, 0, 9, 0);
    run_txn("abort_len6", 4'd6, 1, 0, 9, 0);
    run_txn("devsel_late", 4'd3, 0, 0, DEVSEL_TO - 1, 0);
  endtask
  task automatic test_bus_busy();
    run_txn("bus_busy", 4'd2, 0, 3, 0, 0);
  endtask
  task automatic test_mid_reset();
    bit hit = 0;
    @(negedge clk);
    bus_if.start  = 1'b1;
    bus_if.burst_len = 4'd4;
    bus_if.GNT    = 1'b0;
    bus_if.TRDY   = 1'b0;
    bus_if.DEVSEL = 1'b0;
    for (int cyc = 0; cyc < 50 && !hit; cyc++) begin
      @(negedge clk);
      bus_if.start = 1'b0;
      if (bus_if.phase_cnt == 4'd2) hit = 1;
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL mid_reset_reach: phase_cnt got %0d expected 2", bus_if.phase_cnt);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus_if.REQ, bus_if.FRAME, bus_if.IRDY, bus_if.I_AM_OWNER, bus_if.done, bus_if.abort, bus_if.phase_cnt} !== 10'b1110_00_0000) begin
      failures++;
      $display("FAIL mid_reset_state: got %b expected 1110000000",
               {bus_if.REQ, bus_if.FRAME, bus_if.IRDY, bus_if.I_AM_OWNER, bus_if.done, bus_if.abort, bus_if.phase_cnt});
    end
    rst = 1'b0;
    idle_inputs();
    run_txn("after_reset", 4'd4, 0, 0, 0, 0);
  endtask
  task automatic test_back_to_back();
    for (int n = 0; n < 20; n++) begin
      int d;
      d = $urandom_range(0, 4) == 0 ? int'($urandom_range(DEVSEL_TO, DEVSEL_TO + 2)) : int'($urandom_range(0, DEVSEL_TO - 1));
      run_txn("random", 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), d, 1);
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_wait_states();
    test_clamp();
    test_abort();
    test_bus_busy();
    test_mid_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
